ksa_nibble_serial_adder: RTL and testbench

Nibble-serial wide adder built around a 4-bit Kogge-Stone prefix slice with carry-in. It accepts one WIDTH-bit operand pair with valid/ready, adds one 4-bit nibble per clock LSB-first, and carries between nibbles in a register. It then presents the full sum, carry-out and signed overflow with valid/ready. It is the sequencing stage wrapped around the combinational 4-bit KSA slice, giving area-cheap wide addition.

---
 rtl/ksa_nibble_serial_adder_if.sv | 46 ++++
 rtl/ksa_nibble_serial_adder.sv | 156 +++++++++++++++
 tb/tb_ksa_nibble_serial_adder.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ksa_nibble_serial_adder_if.sv
// ksa_nibble_serial_adder_if
//
// Bundles the operand-side and result-side handshakes of the nibble-serial
// adder so that the driver and the adder connect through one port.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. The producer holds its payload stable while valid is high and ready
//   is low. On the operand channel the producer may drop valid without a
//   transfer, and the adder samples a/b/cin only on the transfer edge.
//
// Signals:
//   in_valid / in_ready   operand channel handshake (driver -> adder)
//   a, b, cin             operand pair and carry into bit 0
//   out_valid / out_ready result channel handshake (adder -> consumer)
//   sum, cout, ovf        result: a+b+cin mod 2^WIDTH, carry out, signed ovf
//   state_dbg             current sequencer state (IDLE=0, RUN=1, DONE=2)
//
// Modports:
//   master  drives operands and out_ready, observes everything else
//   slave   the adder side
interface ksa_nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [1:0]       state_dbg;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, state_dbg
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, state_dbg
  );
endinterface

// File: rtl/ksa_nibble_serial_adder.sv
// ksa_nibble_serial_adder
//
// Wide adder that processes one 4-bit nibble per clock, LSB first, through a
// combinational 4-bit Kogge-Stone prefix slice. The inter-nibble carry lives
// in a register, so a WIDTH-bit add costs WIDTH/4 cycles but only one 4-bit
// slice of carry logic.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    ksa_nibble_serial_adder_if.slave (operand and result handshakes,
//          plus state_dbg exposing the sequencer state)
//
// Sequencing:
//   IDLE  in_ready=1; an accepted pair loads the operand shift registers and
//         seeds the carry register with cin.
//   RUN   NIBBLES cycles, one slice add per cycle; the final cycle also
//         latches cout and ovf.
//   DONE  out_valid=1 with sum/cout/ovf held until out_ready.
//
// WIDTH must be a multiple of 4 and at least 8.
module ksa_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  ksa_nibble_serial_adder_if.slave bus
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic accept;
  logic last_nibble;

  // ---------------------------------------------------------------------
  // 4-bit Kogge-Stone slice with carry-in
  // ---------------------------------------------------------------------
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] g1;
  logic [3:0] p1;
  logic [3:0] g2;
  logic [3:0] p2;
  logic [3:0] c;
  logic [3:0] s;

  always_comb begin
    p  = a_sh_q[3:0] ^ b_sh_q[3:0];
    g  = a_sh_q[3:0] & b_sh_q[3:0];

    // Prefix level 1, distance 1.
    g1 = g;
    p1 = p;
    for (int i = 1; i < 4; i++) begin
      g1[i] = g[i] | (p[i] & g[i-1]);
      p1[i] = p[i] & p[i-1];
    end

    // Prefix level 2, distance 2. After this G2[i]/P2[i] span bits [i:0].
    g2 = g1;
    p2 = p1;
    for (int i = 2; i < 4; i++) begin
      g2[i] = g1[i] | (p1[i] & g1[i-2]);
      p2[i] = p1[i] & p1[i-2];
    end

    // Fold in the carry register as the prefix's bit -1 generate.
    c = g2 | (p2 & {4{carry_q}});
    s = p ^ {c[2:0], carry_q};
  end

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  assign accept      = (state_q == IDLE) && bus.in_valid;
  assign last_nibble = (state_q == RUN) && (cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid)  state_d = RUN;
      RUN:  if (last_nibble)   state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_sh_q  <= bus.a;
      b_sh_q  <= bus.b;
      // Seeding from cin here is what keeps a carry from an aborted
      // operation out of the next one.
      carry_q <= bus.cin;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_sh_q  <= a_sh_q >> 4;
      b_sh_q  <= b_sh_q >> 4;
      carry_q <= c[3];
      cnt_q   <= cnt_q + CNT_W'(1);
      // Nibbles enter at the top so that after NIBBLES shifts the first
      // (least significant) nibble has reached bits [3:0].
      sum_q   <= {s, sum_q[WIDTH-1:4]};
      if (last_nibble) begin
        cout_q <= c[3];
        // Carry into the MSB XOR carry out of it.
        ovf_q  <= c[2] ^ c[3];
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_ksa_nibble_serial_adder.sv
// tb_ksa_nibble_serial_adder
//
// Bench for the nibble-serial adder at WIDTH=16. Expected results are
// {cout, ovf, sum} words pushed to exp_q at the accept edge and popped when
// the result appears.
module tb_ksa_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int W     = WIDTH + 2;
  localparam int LAT   = WIDTH / 4;

  logic clk;
  logic rst_n;

  ksa_nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  ksa_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain wide addition, ovf from operand/result sign bits.
  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic cin);
    logic [WIDTH:0] t;
    logic           v;
    t = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    v = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    return {t[WIDTH], v, t[WIDTH-1:0]};
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at a negedge)
  // ---------------------------------------------------------------------
  task automatic accept_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic [W-1:0] exp,
                           input logic do_push);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: in_ready=%b required 1", bus.in_ready);
    end
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    if (do_push) exp_q.push_back(exp);
    @(negedge clk);
    bus.in_valid = 1'b0;
    // Operands may change freely once accepted.
    bus.a   = WIDTH'($urandom_range(0, 16'hFFFF));
    bus.b   = WIDTH'($urandom_range(0, 16'hFFFF));
    bus.cin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      checks++;
      errors++;
      $display("FAIL result_wait: out_valid=%b after %0d cycles", bus.out_valid, lat);
    end
  endtask

  // ---------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------
  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: ov=%b sum=%h cout=%b ovf=%b ir=%b required 0 0000 0 0 1",
               bus.out_valid, bus.sum, bus.cout, bus.ovf, bus.in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b state=%0d required 1 0", bus.in_ready, bus.state_dbg);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic [W-1:0] exp;
    bus.out_ready = 1'b1;
    accept_op(16'h1234, 16'h4321, 1'b0, {1'b0, 1'b0, 16'h5555}, 1'b1);
    wait_result(lat);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL basic_latency: got %0d required %0d", lat, LAT);
    end
    checks++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    if ({bus.cout, bus.ovf, bus.sum} !== exp) begin
      errors++;
      $display("FAIL basic_result: got %h required %h", {bus.cout, bus.ovf, bus.sum}, exp);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_return_idle: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  // Carry ripple and signed-overflow corners with constant expectations.
  task automatic test_corners();
    logic [WIDTH-1:0] ta [0:4];
    logic [WIDTH-1:0] tb [0:4];
    logic             tc [0:4];
    logic [W-1:0]     te [0:4];
    logic [W-1:0]     exp;
    int lat;
    ta = '{16'hFFFF, 16'h0FFF, 16'h7FFF, 16'h8000, 16'hFFFF};
    tb = '{16'h0000, 16'h0001, 16'h0001, 16'h8000, 16'h0001};
    tc = '{1'b1,     1'b0,     1'b0,     1'b0,     1'b0};
    te = '{{1'b1, 1'b0, 16'h0000}, {1'b0, 1'b0, 16'h1000}, {1'b0, 1'b1, 16'h8000},
           {1'b1, 1'b1, 16'h0000}, {1'b1, 1'b0, 16'h0000}};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      accept_op(ta[i], tb[i], tc[i], te[i], 1'b1);
      wait_result(lat);
      checks++;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      if ({bus.cout, bus.ovf, bus.sum} !== exp) begin
        errors++;
        $display("FAIL corner_%0d: got %h required %h", i, {bus.cout, bus.ovf, bus.sum}, exp);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic [W-1:0]     exp;
    int lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = WIDTH'($urandom_range(0, 16'hFFFF));
      b = WIDTH'($urandom_range(0, 16'hFFFF));
      c = 1'($urandom_range(0, 1));
      accept_op(a, b, c, model(a, b, c), 1'b1);
      wait_result(lat);
      checks++;
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      if ({bus.cout, bus.ovf, bus.sum} !== exp || lat !== LAT) begin
        errors++;
        $display("FAIL random_%0d: got %h lat %0d required %h lat %0d",
                 i, {bus.cout, bus.ovf, bus.sum}, lat, exp, LAT);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp;
    int lat;
    bus.out_ready = 1'b0;
    accept_op(16'hA5A5, 16'h5A5A, 1'b0, {1'b0, 1'b0, 16'hFFFF}, 1'b1);
    wait_result(lat);
    checks++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    if ({bus.cout, bus.ovf, bus.sum} !== exp) begin
      errors++;
      $display("FAIL bp_result: got %h required %h", {bus.cout, bus.ovf, bus.sum}, exp);
    end
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    bus.cin      = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== 16'hFFFF) begin
        errors++;
        $display("FAIL bp_hold_%0d: ov=%b ir=%b sum=%h required 1 0 ffff",
                 i, bus.out_valid, bus.in_ready, bus.sum);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
    // in_valid is still high, so this edge accepts the waiting pair.
    @(posedge clk);
    exp_q.push_back(model(16'h1111, 16'h2222, 1'b1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result(lat);
    checks++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    if ({bus.cout, bus.ovf, bus.sum} !== exp || lat !== LAT) begin
      errors++;
      $display("FAIL bp_next: got %h lat %0d required %h lat %0d",
               {bus.cout, bus.ovf, bus.sum}, lat, exp, LAT);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] exp;
    int lat;
    bus.out_ready = 1'b1;
    accept_op(16'hFFFF, 16'h0001, 1'b1, '0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_reset: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    accept_op(16'h0001, 16'h0001, 1'b0, {1'b0, 1'b0, 16'h0002}, 1'b1);
    wait_result(lat);
    checks++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    if ({bus.cout, bus.ovf, bus.sum} !== exp || lat !== LAT) begin
      errors++;
      $display("FAIL after_mid_run_reset: got %h lat %0d required %h lat %0d",
               {bus.cout, bus.ovf, bus.sum}, lat, exp, LAT);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_done();
    logic [W-1:0] exp;
    int lat;
    bus.out_ready = 1'b0;
    accept_op(16'h8000, 16'h8000, 1'b0, {1'b1, 1'b1, 16'h0000}, 1'b1);
    wait_result(lat);
    checks++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    if ({bus.cout, bus.ovf, bus.sum} !== exp) begin
      errors++;
      $display("FAIL mid_done_result: got %h required %h", {bus.cout, bus.ovf, bus.sum}, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.cout, bus.ovf, bus.in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL mid_done_reset: ov=%b cout=%b ovf=%b ir=%b required 0 0 0 1",
               bus.out_valid, bus.cout, bus.ovf, bus.in_ready);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_reset_mid_done();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
